// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
//
// Shared definitions for the parametrised serial sequence detector:
//   - default pattern-window and match-counter widths,
//   - the overlap-mode enumeration,
//   - sizing helpers for the history register and the fill counter.
//
// Optional feature macro used elsewhere in this slice: SEQ_DET_MATCH_CNT_EN
// -----------------------------------------------------------------------------
package seq_det_pkg;

  localparam int PATTERN_W_DEF = 4;
  localparam int CNT_W_DEF     = 16;

  // Detection mode latched from cfg_overlap.
  typedef enum logic {
    MODE_NON_OVERLAP = 1'b0,
    MODE_OVERLAP     = 1'b1
  } overlap_mode_e;

  // Highest fill count: the window is "full" once PATTERN_W-1 history bits
  // are held, because the newest bit comes straight from the input.
  function automatic int fill_max(input int pw);
    return pw - 1;
  endfunction

  // Fill counter holds 0..pw-1; keep at least one bit so PATTERN_W=1 still
  // produces a legal (constant-zero) counter.
  function automatic int fill_w(input int pw);
    return (pw > 1) ? $clog2(pw) : 1;
  endfunction

  // History register is PATTERN_W-1 bits; PATTERN_W=1 gets a one-bit stub
  // that the parent ignores.
  function automatic int hist_w(input int pw);
    return (pw > 1) ? pw - 1 : 1;
  endfunction

endpackage : seq_det_pkg

// File: rtl/seq_detector_param_if.sv
// -----------------------------------------------------------------------------
// seq_detector_param_if
//
// Serial-input / configuration / match bundle of the sequence detector.
//   in_valid     qualifies in
//   in           serial data bit
//   cfg_load     one-cycle strobe latching cfg_pattern/cfg_mask/cfg_overlap
//   cfg_pattern  pattern, MSB = oldest bit
//   cfg_mask     1 = compare bit, 0 = don't care
//   cfg_overlap  1 = overlapping detection
//   out          Mealy match (combinational)
//   sync_out     out delayed by one clock
//   match_cnt    saturating match count (only with SEQ_DET_MATCH_CNT_EN)
//
// Modports: master drives the stream and configuration, slave is the detector.
// -----------------------------------------------------------------------------
interface seq_detector_param_if
  import seq_det_pkg::*;
#(
  parameter int PATTERN_W = PATTERN_W_DEF
`ifdef SEQ_DET_MATCH_CNT_EN
  ,
  parameter int CNT_W     = CNT_W_DEF
`endif
);

  logic                 in_valid;
  logic                 in;
  logic                 cfg_load;
  logic [PATTERN_W-1:0] cfg_pattern;
  logic [PATTERN_W-1:0] cfg_mask;
  logic                 cfg_overlap;
  logic                 out;
  logic                 sync_out;
`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0]     match_cnt;
`endif

  modport master (
    output in_valid, in, cfg_load, cfg_pattern, cfg_mask, cfg_overlap,
    input  out, sync_out
`ifdef SEQ_DET_MATCH_CNT_EN
    ,
    input  match_cnt
`endif
  );

  modport slave (
    input  in_valid, in, cfg_load, cfg_pattern, cfg_mask, cfg_overlap,
    output out, sync_out
`ifdef SEQ_DET_MATCH_CNT_EN
    ,
    output match_cnt
`endif
  );

endinterface : seq_detector_param_if

// File: rtl/seq_det_window.sv
// -----------------------------------------------------------------------------
// seq_det_window
//
// History shift register plus saturating fill counter for the sequence
// detector. The newest bit is not stored here; the parent concatenates the
// live input onto history to form the candidate word.
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset (clears history and fill)
//   shift_en    shift in and count one valid bit
//   clear_fill  force the fill count to zero (wins over the increment)
//   in          serial bit to shift in
//   history     last PATTERN_W-1 accepted bits, bit 0 newest
//   full        fill count has reached PATTERN_W-1
// -----------------------------------------------------------------------------
module seq_det_window
  import seq_det_pkg::*;
#(
  parameter int PATTERN_W = PATTERN_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          shift_en,
  input  logic                          clear_fill,
  input  logic                          in,
  output logic [hist_w(PATTERN_W)-1:0]  history,
  output logic                          full
);

  localparam int              HIST_W   = hist_w(PATTERN_W);
  localparam int              FILL_W   = fill_w(PATTERN_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(fill_max(PATTERN_W));

  logic [HIST_W-1:0] history_q, history_d;
  logic [FILL_W-1:0] fill_q, fill_d;

  // NOTE: every always_comb output gets a default assignment first, so no
  // path through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    history_d = history_q;
    fill_d    = fill_q;
    if (shift_en) begin
      history_d = (history_q << 1) | HIST_W'(in);
      if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
    // Non-overlapping matches and configuration loads restart the fill even
    // when a bit is shifted in the same cycle.
    if (clear_fill) begin
      fill_d = '0;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      history_q <= '0;
      fill_q    <= '0;
    end else begin
      history_q <= history_d;
      fill_q    <= fill_d;
    end
  end

  assign history = history_q;
  assign full    = (fill_q == FILL_MAX);

endmodule : seq_det_window

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
//
// Run-time-programmable serial pattern detector. A PATTERN_W-bit candidate
// word {history, in} is compared against the latched pattern under a
// per-bit care mask. Overlapping or non-overlapping detection is selected
// at configuration time.
//
// Parameters:
//   PATTERN_W  pattern/window length, 1..32
//   CNT_W      match counter width (used with SEQ_DET_MATCH_CNT_EN)
//
// Ports:
//   clk  clock, rising edge
//   rst  synchronous active-high reset
//   bus  seq_detector_param_if.slave:
//          in_valid/in stream, cfg_load/cfg_pattern/cfg_mask/cfg_overlap
//          configuration, out (Mealy match), sync_out (out + 1 cycle),
//          match_cnt (only when SEQ_DET_MATCH_CNT_EN is defined)
//
// Optional feature: define SEQ_DET_MATCH_CNT_EN to add a saturating match
// counter that clears on rst or cfg_load.
// -----------------------------------------------------------------------------
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int PATTERN_W = PATTERN_W_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_detector_param_if.slave  bus
);

  localparam int HIST_W = hist_w(PATTERN_W);

  if (PATTERN_W < 1 || PATTERN_W > 32 || CNT_W < 1) begin : g_param_check
    $error("seq_detector_param: PATTERN_W must be 1..32 and CNT_W >= 1");
  end

  // ---------------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------------
  logic [PATTERN_W-1:0] pattern_q;
  logic [PATTERN_W-1:0] mask_q;
  overlap_mode_e        overlap_q;

  // NOTE: configuration registers are reset to defined values (pattern 0,
  // compare every bit, overlapping) so the detector is usable straight out of
  // reset without a cfg_load.
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q <= '0;
      mask_q    <= '1;
      overlap_q <= MODE_OVERLAP;
    end else if (bus.cfg_load) begin
      pattern_q <= bus.cfg_pattern;
      mask_q    <= bus.cfg_mask;
      overlap_q <= overlap_mode_e'(bus.cfg_overlap);
    end
  end

  // ---------------------------------------------------------------------------
  // Window
  // ---------------------------------------------------------------------------
  logic              shift_en;
  logic              clear_fill;
  logic [HIST_W-1:0] history;
  logic              full;

  seq_det_window #(
    .PATTERN_W (PATTERN_W)
  ) u_window (
    .clk        (clk),
    .rst        (rst),
    .shift_en   (shift_en),
    .clear_fill (clear_fill),
    .in         (bus.in),
    .history    (history),
    .full       (full)
  );

  // Candidate word: stored history with the live bit appended as the newest.
  logic [PATTERN_W-1:0] candidate;

  if (PATTERN_W == 1) begin : g_cand_single
    assign candidate = bus.in;
  end else begin : g_cand_multi
    assign candidate = {history, bus.in};
  end

  // ---------------------------------------------------------------------------
  // Match and window control
  // ---------------------------------------------------------------------------
  logic match;

  always_comb begin
    match      = 1'b0;
    shift_en   = 1'b0;
    clear_fill = 1'b0;

    // cfg_load takes the cycle: the bit is dropped and no match is reported.
    if (bus.in_valid && !bus.cfg_load && !rst && full) begin
      match = (((candidate ^ pattern_q) & mask_q) == '0);
    end

    shift_en   = bus.in_valid && !bus.cfg_load;
    clear_fill = bus.cfg_load || (match && (overlap_q == MODE_NON_OVERLAP));
  end

  assign bus.out = match;

  // ---------------------------------------------------------------------------
  // Registered match
  // ---------------------------------------------------------------------------
  logic sync_out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_out_q <= 1'b0;
    end else begin
      sync_out_q <= match;
    end
  end

  assign bus.sync_out = sync_out_q;

`ifdef SEQ_DET_MATCH_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating match counter
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] match_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || bus.cfg_load) begin
      match_cnt_q <= '0;
    end else if (match && (match_cnt_q != '1)) begin
      match_cnt_q <= match_cnt_q + CNT_W'(1);
    end
  end

  assign bus.match_cnt = match_cnt_q;
`endif

endmodule : seq_detector_param

// File: tb/tb_seq_detector_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_param
//
// Directed bench for seq_detector_param with PATTERN_W=4 and CNT_W=2.
// Each driven cycle pushes its expected Mealy result to a scoreboard queue;
// out is popped and compared within the cycle and sync_out one edge later.
// Match-counter checks are present when SEQ_DET_MATCH_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_seq_detector_param;

  localparam int PW = 4;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

`ifdef SEQ_DET_MATCH_CNT_EN
  seq_detector_param_if #(.PATTERN_W(PW), .CNT_W(CW)) bus ();
`else
  seq_detector_param_if #(.PATTERN_W(PW)) bus ();
`endif

  seq_detector_param #(
    .PATTERN_W (PW),
    .CNT_W     (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_out_q[$];
  logic exp_sync_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, check out before the rising edge,
  // check sync_out just after it.
  task automatic drive(input logic v, input logic b, input logic ld,
                       input logic rs, input logic exp, input string tag);
    logic e;
    @(negedge clk);
    bus.in_valid = v;
    bus.in       = b;
    bus.cfg_load = ld;
    rst          = rs;
    exp_out_q.push_back(exp);
    exp_sync_q.push_back(exp);
    #1;
    e = exp_out_q.pop_front();
    check({tag, " out"}, 32'(bus.out), 32'(e));
    @(posedge clk);
    #1;
    e = exp_sync_q.pop_front();
    check({tag, " sync_out"}, 32'(bus.sync_out), 32'(e));
  endtask

  task automatic load(input logic [PW-1:0] pat, input logic [PW-1:0] msk,
                      input logic ov, input string tag);
    bus.cfg_pattern = pat;
    bus.cfg_mask    = msk;
    bus.cfg_overlap = ov;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, tag);
  endtask

  task automatic bit_in(input logic b, input logic exp, input string tag);
    drive(1'b1, b, 1'b0, 1'b0, exp, tag);
  endtask

  task automatic cnt_check(input int exp, input string tag);
`ifdef SEQ_DET_MATCH_CNT_EN
    check(tag, 32'(bus.match_cnt), 32'(exp));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in          = 1'b0;
    bus.cfg_load    = 1'b0;
    bus.cfg_pattern = '0;
    bus.cfg_mask    = '0;
    bus.cfg_overlap = 1'b0;

    // Reset: out held low even with a valid bit present.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "reset0");
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "reset1");
    cnt_check(0, "reset match_cnt");

    // Overlapping 1011 on 1,0,1,1,0,1,1: matches on bits 4 and 7.
    load(4'b1011, 4'b1111, 1'b1, "ovl load");
    bit_in(1'b1, 1'b0, "ovl b1");
    bit_in(1'b0, 1'b0, "ovl b2");
    bit_in(1'b1, 1'b0, "ovl b3");
    bit_in(1'b1, 1'b1, "ovl b4");
    bit_in(1'b0, 1'b0, "ovl b5");
    bit_in(1'b1, 1'b0, "ovl b6");
    bit_in(1'b1, 1'b1, "ovl b7");
    cnt_check(2, "ovl match_cnt");

    // Non-overlapping: bit 7 lacks a full fresh window.
    load(4'b1011, 4'b1111, 1'b0, "novl load");
    cnt_check(0, "novl load clears match_cnt");
    bit_in(1'b1, 1'b0, "novl b1");
    bit_in(1'b0, 1'b0, "novl b2");
    bit_in(1'b1, 1'b0, "novl b3");
    bit_in(1'b1, 1'b1, "novl b4");
    bit_in(1'b0, 1'b0, "novl b5");
    bit_in(1'b1, 1'b0, "novl b6");
    bit_in(1'b1, 1'b0, "novl b7");
    cnt_check(1, "novl match_cnt");

    // Mask 1011: bit 2 is don't care.
    load(4'b1011, 4'b1011, 1'b1, "mask load");
    bit_in(1'b1, 1'b0, "mask1 b1");
    bit_in(1'b1, 1'b0, "mask1 b2");
    bit_in(1'b1, 1'b0, "mask1 b3");
    bit_in(1'b1, 1'b1, "mask1 b4");
    load(4'b1011, 4'b1011, 1'b1, "mask reload");
    bit_in(1'b1, 1'b0, "mask2 b1");
    bit_in(1'b0, 1'b0, "mask2 b2");
    bit_in(1'b1, 1'b0, "mask2 b3");
    bit_in(1'b0, 1'b0, "mask2 b4");

    // in_valid gap: state held, in ignored while invalid.
    load(4'b1011, 4'b1111, 1'b1, "gap load");
    bit_in(1'b1, 1'b0, "gap b1");
    bit_in(1'b0, 1'b0, "gap b2");
    bit_in(1'b1, 1'b0, "gap b3");
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "gap idle");
    end
    bit_in(1'b1, 1'b1, "gap b4");

    // cfg_load coincident with the completing bit wins and clears fill.
    load(4'b1011, 4'b1111, 1'b1, "coinc load");
    bit_in(1'b1, 1'b0, "coinc b1");
    bit_in(1'b0, 1'b0, "coinc b2");
    bit_in(1'b1, 1'b0, "coinc b3");
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "coinc load+bit");
    bit_in(1'b1, 1'b0, "coinc n1");
    bit_in(1'b0, 1'b0, "coinc n2");
    bit_in(1'b1, 1'b0, "coinc n3");
    bit_in(1'b1, 1'b1, "coinc n4");

    // Reset mid-sequence: history discarded, config returns to pattern 0000
    // with full mask, so four fresh zeros are needed for the next match.
    bit_in(1'b1, 1'b0, "rstmid b1");
    bit_in(1'b0, 1'b0, "rstmid b2");
    bit_in(1'b1, 1'b0, "rstmid b3");
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "rstmid pulse");
    cnt_check(0, "rstmid match_cnt");
    bit_in(1'b1, 1'b0, "post rst b1");
    bit_in(1'b0, 1'b0, "post rst b2");
    bit_in(1'b0, 1'b0, "post rst b3");
    bit_in(1'b0, 1'b0, "post rst b4");
    bit_in(1'b0, 1'b1, "post rst b5");

    // All-zero mask: match on every valid bit once filled; counter saturates.
    load(4'b0000, 4'b0000, 1'b1, "mask0 load");
    bit_in(1'b1, 1'b0, "mask0 fill1");
    bit_in(1'b0, 1'b0, "mask0 fill2");
    bit_in(1'b1, 1'b0, "mask0 fill3");
    for (int i = 0; i < 5; i++) begin
      bit_in(1'(i), 1'b1, "mask0 match");
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "mask0 idle");
    cnt_check(3, "mask0 match_cnt saturated");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_seq_detector_param
